wbqfifo: RTL

Parametrised synchronous FIFO, the successor to the 36/66-bit JTAG-to-wishbone codeword FIFO. It adds true full-depth capacity, a registered fill count, a programmable almost-full flag and explicit full/empty handshakes. Words written at full are dropped and flagged, as are reads at empty. It sits between the JTAG/UART byte-to-codeword converters and the wishbone bus master, in either direction.

---
 rtl/wbqfifo_if.sv | 28 ++
 rtl/wbqfifo.sv | 75 +++++++
 2 files changed

// File: rtl/wbqfifo_if.sv
// Handshake/data bundle for wbqfifo. The producer/consumer side uses
// the master modport and the FIFO uses the slave modport.
interface wbqfifo_if #(
    parameter int BW     = 36,
    parameter int LGFLEN = 10
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic [LGFLEN:0]   i_afull_thresh;
    logic              i_clr_err;
    logic [BW-1:0]     o_data;
    logic              o_empty_n;
    logic              o_full;
    logic              o_afull;
    logic [LGFLEN:0]   o_fill;
    logic              o_err;

    modport master (
        output i_wr, i_data, i_rd, i_afull_thresh, i_clr_err,
        input  o_data, o_empty_n, o_full, o_afull, o_fill, o_err
    );

    modport slave (
        input  i_wr, i_data, i_rd, i_afull_thresh, i_clr_err,
        output o_data, o_empty_n, o_full, o_afull, o_fill, o_err
    );
endinterface

// File: rtl/wbqfifo.sv
// Full-depth synchronous codeword FIFO with registered head, fill count and flags.
// Define WBQFIFO_STICKY_ERR_EN to make o_err sticky until i_clr_err.
module wbqfifo #(
    parameter int BW     = 36,
    parameter int LGFLEN = 10
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    wbqfifo_if.slave bus
);
    localparam int PW   = LGFLEN + 1;
    localparam int FLEN = 1 << LGFLEN;

    logic [BW-1:0] mem [FLEN];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, fill_nxt;
    logic          rd_ok, wr_ok, err_evt;

    assign rd_ok      = bus.i_rd && bus.o_empty_n;
    assign wr_ok      = bus.i_wr && (!bus.o_full || rd_ok);
    assign err_evt    = (bus.i_wr && !wr_ok) || (bus.i_rd && !rd_ok);
    assign rd_ptr_nxt = rd_ptr + PW'(rd_ok);
    assign fill_nxt   = bus.o_fill + PW'(wr_ok) - PW'(rd_ok);

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_ok)
            mem[wr_ptr[LGFLEN-1:0]] <= bus.i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.o_fill    <= '0;
            bus.o_empty_n <= 1'b0;
            bus.o_full    <= 1'b0;
            bus.o_afull   <= 1'b0;
            bus.o_data    <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr        <= rd_ptr_nxt;
            bus.o_fill    <= fill_nxt;
            bus.o_empty_n <= (fill_nxt != '0);
            bus.o_full    <= (fill_nxt == PW'(FLEN));
            bus.o_afull   <= (fill_nxt >= bus.i_afull_thresh);
            // The next head slot is being written right now; RAM would return stale data.
            if (wr_ok && fill_nxt == PW'(1))
                bus.o_data <= bus.i_data;
            else
                bus.o_data <= mem[rd_ptr_nxt[LGFLEN-1:0]];
        end
    end

`ifdef WBQFIFO_STICKY_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            bus.o_err <= 1'b0;
        else if (err_evt)
            bus.o_err <= 1'b1;
        else if (bus.i_clr_err)
            bus.o_err <= 1'b0;
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.i_clr_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            bus.o_err <= 1'b0;
        else
            bus.o_err <= err_evt;
    end
`endif
endmodule
